fpu_minmax_reduce16: RTL

Streaming min/max reduction engine for fp16 vectors. It accepts one fp16 element per cycle over a valid/ready input and tracks the running minimum, maximum and their indices. Two instances of the existing fp16 comparator (fpuComp16) perform the comparisons. When a batch closes, it presents a single registered result over a valid/ready output. It sits between the vector load path and the FPU writeback as the reduction stage for MIN/MAX/ARGMIN/ARGMAX ops.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpuComp16.sv | 27 ++
 rtl/fpu_minmax_reduce16.sv | 98 +++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared fp16 types and constants for the FPU reduction path.
// Also holds the reduction FSM state encoding.
package fpu_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  localparam fp16_t POS_ZERO = 16'h0000;
  localparam fp16_t NEG_ZERO = 16'h8000;
  localparam fp16_t ONE      = 16'h3C00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } reduce_state_t;

endpackage

// File: rtl/fpuComp16.sv
// fp16 comparator: pure combinational sign-magnitude ordering, -0 < +0,
// NaN/Inf patterns ordered by magnitude with no special-casing.
module fpuComp16
  import fpu_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output logic  lt,
  output logic  gt
);

  // Map sign-magnitude onto an unsigned key so a plain compare gives the order.
  function automatic logic [15:0] order_key(input fp16_t v);
    logic [15:0] bits;
    bits = v;
    return v.sign ? ~bits : {1'b1, bits[14:0]};
  endfunction

  logic [15:0] key_a;
  logic [15:0] key_b;

  assign key_a = order_key(a);
  assign key_b = order_key(b);
  assign lt    = key_a < key_b;
  assign gt    = key_a > key_b;

endmodule

// File: rtl/fpu_minmax_reduce16.sv
// Streaming fp16 min/max/argmin/argmax reduction, one element per cycle.
// Result is registered and held in DONE until out_ready; input stalls meanwhile.
module fpu_minmax_reduce16
  import fpu_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp16_t            in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output fp16_t            out_min,
  output fp16_t            out_max,
  output logic [IDX_W-1:0] out_min_idx,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W:0]   out_count,
  output logic             out_trunc
);

  localparam logic [IDX_W:0] LEN_LAST = (IDX_W+1)'(MAX_LEN - 1);

  reduce_state_t    state, state_nxt;
  fp16_t            min_q, max_q;
  logic [IDX_W-1:0] min_idx_q, max_idx_q;
  logic [IDX_W:0]   count_q;
  logic             trunc_q;

  logic             accept;
  logic [IDX_W:0]   idx_now;
  logic             full;
  logic             x_lt_min, x_gt_max;

  assign in_ready = reset_n && (state != DONE);
  assign accept   = in_valid && in_ready;
  // Index of the incoming element; count_q still holds the previous batch in IDLE.
  assign idx_now  = (state == IDLE) ? '0 : count_q;
  assign full     = (idx_now == LEN_LAST);

  fpuComp16 u_cmp_min (.a(in_data), .b(min_q), .lt(x_lt_min), .gt());
  fpuComp16 u_cmp_max (.a(in_data), .b(max_q), .lt(),        .gt(x_gt_max));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = (in_last || full) ? DONE : ACCUM;
      DONE:        if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      min_q     <= POS_ZERO;
      max_q     <= POS_ZERO;
      min_idx_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
      trunc_q   <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        min_q     <= in_data;
        max_q     <= in_data;
        min_idx_q <= '0;
        max_idx_q <= '0;
      end else begin
        if (x_lt_min) begin
          min_q     <= in_data;
          min_idx_q <= idx_now[IDX_W-1:0];
        end
        if (x_gt_max) begin
          max_q     <= in_data;
          max_idx_q <= idx_now[IDX_W-1:0];
        end
      end
      count_q <= idx_now + 1'b1;
      trunc_q <= full && !in_last;
    end
  end

  assign out_valid   = (state == DONE);
  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
  assign out_count   = count_q;
  assign out_trunc   = trunc_q;

endmodule
